// File: rtl/bpm_detector.sv
// Beat detector: envelope-tracking threshold, beat interval counter and restoring divider that turns intervals into BPM.
// Optional macro BPM_AVG_EN averages the last four accepted intervals before dividing.
module bpm_detector #(
  parameter int unsigned PPG_WIDTH   = 10,
  parameter int unsigned FS_HZ       = 100,
  parameter int unsigned MIN_BPM     = 30,
  parameter int unsigned MAX_BPM     = 200,
  parameter int unsigned DECAY_SHIFT = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        db_en,
  input  logic signed [PPG_WIDTH-1:0] ppg_in,
  output logic        [7:0]           bpm_value,
  output logic                        bpm_valid,
  input  logic                        bpm_copied
);

  localparam int unsigned EW = PPG_WIDTH + 1;
  localparam int unsigned DW = PPG_WIDTH + 2;
  localparam logic [15:0] DIVIDEND = 16'(60 * FS_HZ);
  localparam logic [15:0] MAX_IV   = 16'((60 * FS_HZ) / MIN_BPM);
  localparam logic [15:0] MIN_IV   = 16'((60 * FS_HZ) / MAX_BPM);

  typedef enum logic [1:0] {
    WAIT_FIRST,
    MEASURE,
    DIVIDE
  } state_t;

  state_t               state;
  logic signed [EW-1:0] env_max;
  logic signed [EW-1:0] env_min;
  logic signed [EW-1:0] prev;
  logic        [15:0]   cnt;

  logic        beat_q;
  logic        done;
  logic [15:0] rem;
  logic [15:0] quo;
  logic [15:0] dsr;
  logic [3:0]  iter;

`ifdef BPM_AVG_EN
  logic [15:0] hist [4];
  logic [2:0]  n_acc;
  logic [17:0] hist_sum_c;
`endif

  logic signed [EW-1:0] x_c;
  logic signed [EW-1:0] thr_c;
  logic signed [EW-1:0] max_n_c;
  logic signed [EW-1:0] min_n_c;
  logic                 beat_c;
  logic        [16:0]   shifted_c;

  // Envelope next values, threshold and beat qualification (refractory included)
  always_comb begin
    x_c     = EW'(ppg_in);
    thr_c   = EW'((DW'(env_max) + DW'(env_min)) >>> 1);
    max_n_c = env_max;
    min_n_c = env_min;
    if (x_c > env_max) max_n_c = x_c;
    else               max_n_c = env_max - EW'((DW'(env_max) - DW'(x_c)) >>> DECAY_SHIFT);
    if (x_c < env_min) min_n_c = x_c;
    else               min_n_c = env_min + EW'((DW'(x_c) - DW'(env_min)) >>> DECAY_SHIFT);
    beat_c    = db_en && (prev <= thr_c) && (x_c > thr_c) && (cnt >= MIN_IV);
    shifted_c = {rem, quo[15]};
`ifdef BPM_AVG_EN
    hist_sum_c = 18'(hist[0]) + 18'(hist[1]) + 18'(hist[2]) + 18'(hist[3]);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env_max <= '0;
      env_min <= '0;
      prev    <= '0;
      cnt     <= '0;
    end else if (db_en) begin
      env_max <= max_n_c;
      env_min <= min_n_c;
      prev    <= x_c;
      if (beat_c)              cnt <= 16'd1;
      else if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
  end

  // Beat FSM, divider and result handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_FIRST;
      beat_q    <= 1'b0;
      done      <= 1'b0;
      rem       <= '0;
      quo       <= '0;
      dsr       <= '0;
      iter      <= '0;
      bpm_value <= '0;
      bpm_valid <= 1'b0;
`ifdef BPM_AVG_EN
      for (int i = 0; i < 4; i++) hist[i] <= '0;
      n_acc <= '0;
`endif
    end else begin
      beat_q <= 1'b0;
      done   <= 1'b0;
      case (state)
        WAIT_FIRST: begin
          if (beat_c) state <= MEASURE;
        end
        MEASURE: begin
          if (beat_q) begin
`ifdef BPM_AVG_EN
            if (n_acc == 3'd4) begin
              state <= DIVIDE;
              dsr   <= 16'(hist_sum_c >> 2);
              rem   <= '0;
              quo   <= DIVIDEND;
              iter  <= '0;
            end
`else
            state <= DIVIDE;
            rem   <= '0;
            quo   <= DIVIDEND;
            iter  <= '0;
`endif
          end else if (beat_c && (cnt <= MAX_IV)) begin
            beat_q <= 1'b1;
`ifdef BPM_AVG_EN
            hist[0] <= cnt;
            for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
            if (n_acc != 3'd4) n_acc <= n_acc + 3'd1;
`else
            dsr <= cnt;
`endif
          end else if (cnt > MAX_IV) begin
            // Signal lost: restart from the first beat
            state <= WAIT_FIRST;
`ifdef BPM_AVG_EN
            for (int i = 0; i < 4; i++) hist[i] <= '0;
            n_acc <= '0;
`endif
          end
        end
        DIVIDE: begin
          if (shifted_c >= 17'(dsr)) begin
            rem <= 16'(shifted_c - 17'(dsr));
            quo <= {quo[14:0], 1'b1};
          end else begin
            rem <= shifted_c[15:0];
            quo <= {quo[14:0], 1'b0};
          end
          iter <= iter + 4'd1;
          if (iter == 4'd15) begin
            state <= MEASURE;
            done  <= 1'b1;
          end
        end
        default: state <= WAIT_FIRST;
      endcase

      // A completing result wins over a simultaneous copy acknowledge
      if (done) begin
        bpm_value <= (quo[15:8] != 8'd0) ? 8'hFF : quo[7:0];
        bpm_valid <= 1'b1;
      end else if (bpm_copied) begin
        bpm_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bpm_detector.sv
// Scoreboard bench for bpm_detector: stimulus queues expected BPM values, a monitor pops and acknowledges results.
module tb_bpm_detector;

  localparam logic signed [9:0] BASE = -10'sd100;
  localparam logic signed [9:0] PEAK = 10'sd100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              db_en = 1'b0;
  logic signed [9:0] ppg_in = '0;
  logic [7:0]        bpm_value;
  logic              bpm_valid;
  logic              bpm_copied;
  logic              copied_mon = 1'b0;
  logic              copied_stim = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  bit hold = 1'b0;
  int e;
`ifdef BPM_AVG_EN
  int hist[$];
`endif

  assign bpm_copied = copied_mon | copied_stim;

  always #5 clk = ~clk;

  bpm_detector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .db_en      (db_en),
    .ppg_in     (ppg_in),
    .bpm_value  (bpm_value),
    .bpm_valid  (bpm_valid),
    .bpm_copied (bpm_copied)
  );

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // One sample strobe followed by idle clocks: strobes are 20 clocks apart
  task automatic strobe(input logic signed [9:0] x, input bit lat);
    @(negedge clk);
    db_en  = 1'b1;
    ppg_in = x;
    @(negedge clk);
    db_en = 1'b0;
    for (int i = 2; i <= 19; i++) begin
      @(negedge clk);
      if (lat && i == 18) check("latency_edge17_low", int'(bpm_valid), 0);
      if (lat && i == 19) check("latency_edge18_high", int'(bpm_valid), 1);
    end
  endtask

  task automatic baseline(input int n);
    repeat (n) strobe(BASE, 1'b0);
  endtask

  function automatic int expect_for(input int iv, input int direct);
`ifdef BPM_AVG_EN
    int s;
    int q;
    hist.push_back(iv);
    if (hist.size() > 4) void'(hist.pop_front());
    if (hist.size() < 4) return -1;
    s = 0;
    foreach (hist[i]) s += hist[i];
    q = 6000 / (s >> 2);
    return (q > 255) ? 255 : q;
`else
    return (iv > 0) ? direct : -1;
`endif
  endfunction

  function automatic void model_clear();
`ifdef BPM_AVG_EN
    hist.delete();
`endif
  endfunction

  // Pulse at offset gap; the detector sees interval iv
  task automatic beat(input int gap, input int iv, input int direct, input bit lat, output int ev);
    baseline(gap - 1);
    ev = expect_for(iv, direct);
    if (ev >= 0 && !hold) exp_q.push_back(ev);
    strobe(PEAK, lat);
  endtask

  // Monitor: compare each presented result against the scoreboard, then acknowledge it
  initial begin
    forever begin
      @(negedge clk);
      if (copied_mon) begin
        copied_mon = 1'b0;
      end else if (!hold && rst_n && bpm_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: got value %0d, expected no result", bpm_value);
        end else begin
          check("bpm_value", int'(bpm_value), exp_q.pop_front());
        end
        copied_mon = 1'b1;
      end
    end
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    check("reset_valid", int'(bpm_valid), 0);
    check("reset_value", int'(bpm_value), 0);
    rst_n = 1'b1;

    // Periodic 75-sample beats
    baseline(40);
    strobe(PEAK, 1'b0);
    for (int k = 0; k < 4; k++) beat(75, 75, 80, 1'b0, e);

    // Rate change to 60 samples
    for (int k = 0; k < 3; k++) beat(60, 60, 100, 1'b0, e);

    // Pulses every 20 samples: every other crossing falls in the refractory window
    for (int k = 0; k < 3; k++) begin
      baseline(19);
      strobe(PEAK, 1'b0);
      beat(20, 40, 150, 1'b0, e);
    end

    // Handshake: two results without acknowledge, then copy
    hold = 1'b1;
    beat(75, 75, 80, 1'b1, e);
    check("hs_first_value", int'(bpm_value), e);
    beat(60, 60, 100, 1'b0, e);
    check("hs_still_valid", int'(bpm_valid), 1);
    check("hs_overwritten_value", int'(bpm_value), e);
    @(negedge clk);
    copied_stim = 1'b1;
    @(negedge clk);
    copied_stim = 1'b0;
    check("hs_valid_cleared", int'(bpm_valid), 0);
    @(negedge clk);
    copied_stim = 1'b1;
    @(negedge clk);
    copied_stim = 1'b0;
    check("copy_when_idle_valid", int'(bpm_valid), 0);
    check("copy_when_idle_value", int'(bpm_value), e);
    hold = 1'b0;

    // Signal loss, then two fresh beats
    baseline(250);
    check("loss_no_result", int'(bpm_valid), 0);
    model_clear();
    strobe(PEAK, 1'b0);
    beat(75, 75, 80, 1'b0, e);

    // Reset during the divide
    hold = 1'b1;
    baseline(74);
    @(negedge clk);
    db_en  = 1'b1;
    ppg_in = PEAK;
    @(negedge clk);
    db_en = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_valid", int'(bpm_valid), 0);
    check("abort_value", int'(bpm_value), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    repeat (30) @(negedge clk);
    check("abort_no_late_result", int'(bpm_valid), 0);
    hold = 1'b0;
    baseline(40);
    strobe(PEAK, 1'b0);
    beat(75, 75, 80, 1'b0, e);

    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
